// File: rtl/sync_result_fifo.sv
// Ready/valid result buffer for a synchronous function stage, DEPTH entries, in-order.
// Optional occupancy output `count` is enabled by defining SYNC_FIFO_COUNT_EN.
module sync_result_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out0
`ifdef SYNC_FIFO_COUNT_EN
    ,
    output logic [ADDR_W:0]   count
`endif
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_W:0]  wr_ptr_r;
    logic [ADDR_W:0]  rd_ptr_r;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    // Status, handshakes and head data, all derived from registered pointers only.
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                    (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);
        in_ready  = !full_s && !rst;
        out_valid = !empty_s && !rst;
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        if (out_valid) begin
            out0 = mem_r[rd_ptr_r[ADDR_W-1:0]];
        end else begin
            out0 = {WIDTH{1'b0}};
        end
    end

    // Pointer update; the extra MSB toggles on each wrap so full and empty stay distinct.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(ADDR_W+1){1'b0}};
            rd_ptr_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents are not cleared because empty pointers hide them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= in0;
        end
    end

`ifdef SYNC_FIFO_COUNT_EN
    assign count = wr_ptr_r - rd_ptr_r;
`endif

endmodule

// File: tb/tb_sync_result_fifo.sv
// Self-checking bench for sync_result_fifo: queue-based reference model plus directed scenarios.
// Checks `count` as well when SYNC_FIFO_COUNT_EN is defined.
module tb_sync_result_fifo;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in0;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out0;
`ifdef SYNC_FIFO_COUNT_EN
    logic [ADDR_W:0]   count;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    int               popped[$];
    bit               seen_rst = 1'b0;

    sync_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0)
`ifdef SYNC_FIFO_COUNT_EN
        ,
        .count     (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: an ideal bounded queue updated at each rising edge.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        if (rst) begin
            q.delete();
            seen_rst = 1'b1;
        end else begin
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = out_ready && (q.size() > 0);
            if (do_pop) begin
                popped.push_back(int'(q.pop_front()));
            end
            if (do_push) begin
                q.push_back(in0);
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic             exp_ir;
        logic             exp_ov;
        logic [WIDTH-1:0] exp_o0;
        if (seen_rst) begin
            exp_ir = !rst && (q.size() < DEPTH);
            exp_ov = !rst && (q.size() > 0);
            exp_o0 = exp_ov ? q[0] : 16'd0;
            chk("cyc_in_ready", 32'(in_ready), 32'(exp_ir));
            chk("cyc_out_valid", 32'(out_valid), 32'(exp_ov));
            chk("cyc_out0", 32'(out0), 32'(exp_o0));
`ifdef SYNC_FIFO_COUNT_EN
            chk("cyc_count", 32'(count), 32'(q.size()));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  idx;
        bit  done;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in0       = 16'd0;
        out_ready = 1'b0;

        // Reset then idle
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out0", 32'(out0), 32'd0);
`ifdef SYNC_FIFO_COUNT_EN
        chk("idle_count", 32'(count), 32'd0);
`endif
        step();

        // Single pass-through of 8!
        popped.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in0       = 16'd40320;
        step();
        in_valid = 1'b0;
        chk("pass_out_valid", 32'(out_valid), 32'd1);
        chk("pass_out0", 32'(out0), 32'd40320);
        step();
        chk("pass_out_valid_after", 32'(out_valid), 32'd0);
        chk("pass_popped_n", 32'(popped.size()), 32'd1);
        if (popped.size() == 1) chk("pass_popped_v", 32'(popped[0]), 32'd40320);

        // Fill and stall
        popped.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in0      = 16'(i);
            step();
        end
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_model_size", 32'(q.size()), 32'd4);
`ifdef SYNC_FIFO_COUNT_EN
        chk("fill_count", 32'(count), 32'd4);
`endif
        in0 = 16'd5;
        step();
        step();
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out0", 32'(out0), 32'd1);
        out_ready = 1'b1;
        step();
        chk("firstpop_in_ready", 32'(in_ready), 32'd1);
        chk("firstpop_out0", 32'(out0), 32'd2);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("fill_drained", 32'(out_valid), 32'd0);
        chk("fill_popped_n", 32'(popped.size()), 32'd5);
        for (int i = 0; i < popped.size() && i < 5; i++)
            chk("fill_order", 32'(popped[i]), 32'(i + 1));

        // Simultaneous push and pop while full
        out_ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            in_valid = 1'b1;
            in0      = 16'(i);
            step();
        end
        in0       = 16'd14;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fullpp_in_ready", 32'(in_ready), 32'd1);
        chk("fullpp_out0", 32'(out0), 32'd11);
        chk("fullpp_model_size", 32'(q.size()), 32'd3);
`ifdef SYNC_FIFO_COUNT_EN
        chk("fullpp_count", 32'(count), 32'd3);
`endif
        for (int i = 0; i < 3; i++) step();
        chk("fullpp_drained", 32'(out_valid), 32'd0);

        // Wrap-around stream with toggling consumer
        popped.delete();
        idx  = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            in_valid  = (idx < 20);
            in0       = 16'(idx);
            out_ready = (c % 2 == 1);
            if (in_valid && q.size() < DEPTH) idx++;
            step();
            if (popped.size() == 20) done = 1'b1;
        end
        in_valid = 1'b0;
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_popped_n", 32'(popped.size()), 32'd20);
        for (int i = 0; i < popped.size() && i < 20; i++)
            chk("wrap_order", 32'(popped[i]), 32'(i));

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 100; i <= 102; i++) begin
            in_valid = 1'b1;
            in0      = 16'(i);
            step();
        end
        in_valid = 1'b0;
        chk("midrst_pre_out0", 32'(out0), 32'd100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef SYNC_FIFO_COUNT_EN
        chk("midrst_count", 32'(count), 32'd0);
`endif
        in_valid = 1'b1;
        in0      = 16'd7;
        step();
        in_valid = 1'b0;
        chk("midrst_head_valid", 32'(out_valid), 32'd1);
        chk("midrst_head_out0", 32'(out0), 32'd7);
        step();
        chk("midrst_head_hold", 32'(out0), 32'd7);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
